alu_seq_muldiv: RTL and testbench
=================================

// Module: alu_seq_muldiv
// PURPOSE
//  Execute-stage ALU for the RV32I/M core. Covers all base integer ops plus the M extension.
//  Base ops complete in 1 cycle; MUL*/DIV*/REM* ops iterate over multiple cycles.
//  Valid/ready handshake on both sides, so the pipeline stalls on busy instead of using fixed timing.
//  Width is XLEN-generic (RV32 now, RV64-ready).
// PARAMETERS
//  XLEN        32  operand/result width (power of 2, >=8)
//  MUL_RADIX4  0   0: multiply retires 1 bit/cycle (XLEN iterations); 1: 2 bits/cycle (XLEN/2)
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst_n      in   1     asynchronous active-low reset
//  flush      in   1     sync abort of any in-flight op
//  in_valid   in   1     request valid
//  in_ready   out  1     request accepted when in_valid & in_ready
//  funct3     in   3     RISC-V funct3
//  mod        in   1     funct7[5]: SUB / SRA select
//  muldiv     in   1     funct7[0]: selects M-extension op
//  val1       in   XLEN  rs1 operand
//  val2       in   XLEN  rs2 / immediate operand
//  out_valid  out  1     result valid; held until out_ready
//  out_ready  in   1     consumer accepts result
//  result     out  XLEN  result, stable while out_valid & !out_ready
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, busy=0, in_ready=1 after release.
//  FSM states: IDLE, MUL, DIV, DONE.
//   - in_ready = (state==IDLE) & !flush. Operands, funct3, mod and muldiv are latched on accept.
//  Base op (muldiv=0): IDLE->DONE. out_valid in the cycle after accept (latency 1).
//   - ADD/SUB wraps mod 2^XLEN.
//   - Shift amount = val2[$clog2(XLEN)-1:0]; SRA sign-fills.
//   - SLT is signed, SLTU unsigned; result is 0 or 1, zero-extended.
//  MUL/MULH/MULHSU/MULHU: IDLE->MUL.
//   - Shift-add on |magnitudes| with 2*XLEN accumulator.
//   - Sign fix-up of the product when the operand signs differ.
//   - Returns low half (MUL) or high half (others).
//   - Latency XLEN+1 cycles (XLEN/2+1 if MUL_RADIX4).
//  DIV/DIVU/REM/REMU: IDLE->DIV, restoring divide, 1 quotient bit/cycle, latency XLEN+1.
//   - Signed: divide magnitudes; quotient negated if signs differ; remainder takes dividend sign.
//   - Divide by zero: fast path, latency 1. Quotient = all ones, remainder = val1.
//   - Signed overflow (val1 = -2^(XLEN-1), val2 = -1): fast path, latency 1. Quotient = val1, remainder = 0.
//  DONE: out_valid=1, result held.
//   - out_ready=1 -> IDLE next cycle, out_valid=0.
//   - Back-to-back ops: throughput 1 op per 2 cycles minimum.
//  Undefined muldiv/funct3 combinations cannot occur (funct3 fully decoded); no X on result.
//  flush=1:
//   - Any state -> IDLE next cycle; out_valid=0; iteration counters cleared.
//   - An in_valid in the same cycle is not accepted.
//  rst_n low mid-operation: immediate return to reset values; the partial result is discarded.
//  out_ready with out_valid=0 is ignored.
//  in_valid while busy: not accepted; the requester must hold its operands.
// STRUCTURE
//  alu_pkg holds:
//   - funct3 localparams ADD..AND and MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
//   - FSM state encoding.
//  Sub-module alu_div_iter(XLEN): restoring divider with start/done.
//   - Unsigned magnitudes in; quotient and remainder out.
//   - Top level does sign handling.
//  Multiplier datapath, base ops and FSM stay in alu_seq_muldiv.
// TESTING
//  1. ADD 7+(-3) with mod=1 (SUB 7-(-3)), out_ready=1 -> result 10, out_valid exactly 1 cycle after accept.
//  2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; out_valid after 33 cycles.
//  3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
//  4. Divide by zero: DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5. Overflow: DIV 0x80000000/-1 -> 0x80000000; both latency 1.
//  5. Hold out_ready=0 for 5 cycles after DONE -> result stable, in_ready=0. Then out_ready=1 -> IDLE next cycle.
//  6. Assert flush, then in a separate run rst_n=0, at cycle 10 of a DIV -> out_valid never rises, IDLE next cycle;
//     a new ADD 1+1 then returns 2.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential RV32I/M execute-stage ALU.
//   - funct3 encodings for base integer ops and M-extension ops
//   - FSM state encoding used by alu_seq_muldiv
package alu_pkg;

  // Base integer ops (muldiv = 0)
  localparam logic [2:0] F3_ADD  = 3'b000;  // ADD / SUB (mod)
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;  // SRL / SRA (mod)
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // M-extension ops (muldiv = 1)
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_div_iter.sv
// alu_div_iter: unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               load dividend/divisor and begin (one-cycle pulse)
//   abort               cancel an in-flight divide
//   dividend, divisor   unsigned magnitudes (divisor must be non-zero)
//   done                high in the cycle the final step is being taken
//   quotient, remainder valid while done is high (result of the final step)
// The outputs carry the combinational next-step values so the caller can
// capture the answer on the same edge that retires the last bit.
module alu_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int               CNTW = $clog2(XLEN) + 1;
  localparam logic [CNTW-1:0]  LAST = CNTW'(XLEN - 1);

  logic            run;
  logic [CNTW-1:0] cnt;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvsr;

  logic [XLEN:0]   r_sh;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;

  // The dividend is shifted out of quo's MSB into the partial remainder while
  // quotient bits shift in at the LSB; rem < dvsr keeps r_sh within XLEN+1 bits.
  always_comb begin
    r_sh     = {rem, quo[XLEN-1]};
    diff     = r_sh - {1'b0, dvsr};
    fits     = ~diff[XLEN];
    rem_next = fits ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], fits};
  end

  assign done      = run & (cnt == LAST);
  assign quotient  = quo_next;
  assign remainder = rem_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (abort) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
    end else if (done) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      quo  <= dividend;
      rem  <= '0;
      dvsr <= divisor;
    end else if (run) begin
      quo <= quo_next;
      rem <= rem_next;
    end
  end

endmodule

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: execute-stage ALU for RV32I/M (XLEN-generic).
// Base ops finish one cycle after accept; MUL*/DIV*/REM* iterate. Divide by
// zero and signed overflow take a one-cycle fast path.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous abort of any in-flight op
//   in_valid / in_ready   request handshake (accept when both high)
//   funct3, mod, muldiv   op select (mod = funct7[5], muldiv = funct7[0])
//   val1, val2            rs1 and rs2/immediate operands
//   out_valid / out_ready result handshake; result held until taken
//   result                XLEN-bit result
//   busy                  FSM is not idle
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit MUL_RADIX4 = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            mod,
  input  logic            muldiv,
  input  logic [XLEN-1:0] val1,
  input  logic [XLEN-1:0] val2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int              SHW       = $clog2(XLEN);
  localparam int              CNTW      = $clog2(XLEN) + 1;
  localparam int              MUL_ITERS = MUL_RADIX4 ? XLEN / 2 : XLEN;
  localparam int              MUL_SHIFT = MUL_RADIX4 ? 2 : 1;
  localparam logic [CNTW-1:0] MUL_LAST  = CNTW'(MUL_ITERS - 1);
  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg2_if(input logic n, input logic [2*XLEN-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [XLEN-1:0] base_op(input logic [2:0] f3, input logic m,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic signed [XLEN-1:0] sra;
    logic [SHW-1:0]         sh;
    sa  = a;
    sb  = b;
    sh  = b[SHW-1:0];
    // Kept out of any mixed-sign expression so >>> stays arithmetic.
    sra = sa >>> sh;
    case (f3)
      F3_ADD:  base_op = m ? (a - b) : (a + b);
      F3_SLL:  base_op = a << sh;
      F3_SLT:  base_op = {{(XLEN-1){1'b0}}, (sa < sb)};
      F3_SLTU: base_op = {{(XLEN-1){1'b0}}, (a < b)};
      F3_XOR:  base_op = a ^ b;
      F3_SR: begin
        if (m) base_op = sra;
        else   base_op = a >> sh;
      end
      F3_OR:   base_op = a | b;
      default: base_op = a & b;
    endcase
  endfunction

  state_t state;
  state_t state_next;

  logic [CNTW-1:0]   cnt;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [2*XLEN-1:0] acc;
  logic              mul_hi_q;
  logic              mul_neg_q;
  logic              div_rem_q;
  logic              quo_neg_q;
  logic              rem_neg_q;

  logic              accept;
  logic              is_mul_op;
  logic              is_div_op;
  logic              mul_s1;
  logic              mul_s2;
  logic              m1_neg;
  logic              m2_neg;
  logic              div_signed;
  logic              div_rem;
  logic              d1_neg;
  logic              d2_neg;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   fast_res;
  logic              mul_start;
  logic              div_start;
  logic              imm_done;
  logic [XLEN-1:0]   imm_res;

  logic [2*XLEN-1:0] pp;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod;
  logic              mul_last;

  logic              div_done;
  logic [XLEN-1:0]   div_q;
  logic [XLEN-1:0]   div_r;
  logic              div_last;
  logic [XLEN-1:0]   div_res;

  assign in_ready  = (state == ST_IDLE) & ~flush;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign accept    = in_valid & in_ready;

  // Request decode, evaluated on the live inputs at accept.
  always_comb begin
    is_mul_op  = muldiv & ~funct3[2];
    is_div_op  = muldiv &  funct3[2];
    // rs1 is signed for MUL/MULH/MULHSU, rs2 only for MUL/MULH.
    mul_s1     = (funct3[1:0] != 2'b11);
    mul_s2     = ~funct3[1];
    m1_neg     = mul_s1 & val1[XLEN-1];
    m2_neg     = mul_s2 & val2[XLEN-1];
    div_signed = ~funct3[0];
    div_rem    = funct3[1];
    d1_neg     = div_signed & val1[XLEN-1];
    d2_neg     = div_signed & val2[XLEN-1];
    div_zero   = (val2 == '0);
    div_ovf    = div_signed & (val1 == MIN_NEG) & (val2 == '1);
    if (div_zero) fast_res = div_rem ? val1 : '1;
    else          fast_res = div_rem ? '0 : val1;
    mul_start  = accept & is_mul_op;
    div_start  = accept & is_div_op & ~div_zero & ~div_ovf;
    imm_done   = accept & ~is_mul_op & ~div_start;
    imm_res    = muldiv ? fast_res : base_op(funct3, mod, val1, val2);
  end

  // Multiplier step: the final step's sum is fixed up and captured directly.
  always_comb begin
    pp = '0;
    if (MUL_RADIX4) begin
      case (mplier[1:0])
        2'b01:   pp = mcand;
        2'b10:   pp = mcand << 1;
        2'b11:   pp = mcand + (mcand << 1);
        default: pp = '0;
      endcase
    end else if (mplier[0]) begin
      pp = mcand;
    end
    acc_next = acc + pp;
    prod     = neg2_if(mul_neg_q, acc_next);
    mul_last = (state == ST_MUL) & (cnt == MUL_LAST);
  end

  alu_div_iter #(
    .XLEN(XLEN)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .abort    (flush),
    .dividend (neg_if(d1_neg, val1)),
    .divisor  (neg_if(d2_neg, val2)),
    .done     (div_done),
    .quotient (div_q),
    .remainder(div_r)
  );

  always_comb begin
    div_last = (state == ST_DIV) & div_done;
    div_res  = div_rem_q ? neg_if(rem_neg_q, div_r) : neg_if(quo_neg_q, div_q);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (mul_start)      state_next = ST_MUL;
        else if (div_start) state_next = ST_DIV;
        else if (imm_done)  state_next = ST_DONE;
      end
      ST_MUL:  if (mul_last)  state_next = ST_DONE;
      ST_DIV:  if (div_done)  state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      result <= '0;
    end else begin
      if (flush || mul_start || mul_last) cnt <= '0;
      else if (state == ST_MUL)           cnt <= cnt + 1'b1;
      if (!flush) begin
        if (imm_done)      result <= imm_res;
        else if (mul_last) result <= mul_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        else if (div_last) result <= div_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mul_start) begin
      mcand     <= {{XLEN{1'b0}}, neg_if(m1_neg, val1)};
      mplier    <= neg_if(m2_neg, val2);
      acc       <= '0;
      mul_hi_q  <= (funct3 != F3_MUL);
      mul_neg_q <= m1_neg ^ m2_neg;
    end else if (state == ST_MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << MUL_SHIFT;
      mplier <= mplier >> MUL_SHIFT;
    end
    if (div_start) begin
      div_rem_q <= div_rem;
      quo_neg_q <= d1_neg ^ d2_neg;
      rem_neg_q <= d1_neg;
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// tb_alu_seq_muldiv: directed self-checking bench for alu_seq_muldiv (XLEN=32).
module tb_alu_seq_muldiv;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic        mod;
  logic        muldiv;
  logic [31:0] val1;
  logic [31:0] val2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq_muldiv #(.XLEN(32), .MUL_RADIX4(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .funct3   (funct3),
    .mod      (mod),
    .muldiv   (muldiv),
    .val1     (val1),
    .val2     (val2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one request, let it be accepted, then wait (bounded) for out_valid.
  // lat counts edges from the accept edge (1 = valid right after accept).
  task automatic issue(input logic [2:0] f3, input logic m, input logic md,
                       input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    funct3 = f3; mod = m; muldiv = md; val1 = a; val2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("timeout", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic op_chk(input string tag, input logic [2:0] f3, input logic m, input logic md,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    out_ready = 1'b1;
    issue(f3, m, md, a, b, lat);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_lat"}, lat, exp_lat);
    @(posedge clk); #1;
    chk({tag, "_idle"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; funct3 = '0; mod = 1'b0;
    muldiv = 1'b0; val1 = '0; val2 = '0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    chk("rst_result",    result,             32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);

    // Base ops, latency 1
    op_chk("add",  F3_ADD,  1'b0, 1'b0, 32'd7,        32'hFFFF_FFFD, 32'd4,          1);
    op_chk("sub",  F3_ADD,  1'b1, 1'b0, 32'd7,        32'hFFFF_FFFD, 32'd10,         1);
    op_chk("sll",  F3_SLL,  1'b0, 1'b0, 32'd1,        32'd33,        32'd2,          1);
    op_chk("srl",  F3_SR,   1'b0, 1'b0, 32'h8000_0000, 32'd4,        32'h0800_0000,  1);
    op_chk("sra",  F3_SR,   1'b1, 1'b0, 32'h8000_0000, 32'd4,        32'hF800_0000,  1);
    op_chk("slt",  F3_SLT,  1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,        32'd1,          1);
    op_chk("sltu", F3_SLTU, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,        32'd0,          1);
    op_chk("xor",  F3_XOR,  1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
    op_chk("or",   F3_OR,   1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1);
    op_chk("and",  F3_AND,  1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);

    // Multiply, latency 33
    op_chk("mul",    F3_MUL,    1'b0, 1'b1, 32'd6,         32'hFFFF_FFF9, 32'hFFFF_FFD6, 33);
    op_chk("mulh",   F3_MULH,   1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    op_chk("mulhsu", F3_MULHSU, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    op_chk("mulhu",  F3_MULHU,  1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);

    // Divide, latency 33
    op_chk("div",  F3_DIV,  1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    op_chk("rem",  F3_REM,  1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    op_chk("divu", F3_DIVU, 1'b0, 1'b1, 32'd100,       32'd7, 32'd14,        33);
    op_chk("remu", F3_REMU, 1'b0, 1'b1, 32'd100,       32'd7, 32'd2,         33);

    // Fast paths, latency 1
    op_chk("divu_z",  F3_DIVU, 1'b0, 1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    op_chk("rem_z",   F3_REM,  1'b0, 1'b1, 32'd5,         32'd0,         32'd5,         1);
    op_chk("div_ovf", F3_DIV,  1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    op_chk("rem_ovf", F3_REM,  1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Result held while the consumer stalls
    out_ready = 1'b0;
    issue(F3_ADD, 1'b0, 1'b0, 32'd2, 32'd3, lat);
    chk("hold_lat", lat, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_res",   result,              32'd5);
      chk("hold_vld",   {31'b0, out_valid},  32'd1);
      chk("hold_inrdy", {31'b0, in_ready},   32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_rel_vld",  {31'b0, out_valid}, 32'd0);
    chk("hold_rel_busy", {31'b0, busy},      32'd0);

    // Flush at cycle 10 of a DIV, with a competing request in the flush cycle
    @(negedge clk);
    funct3 = F3_DIV; mod = 1'b0; muldiv = 1'b1; val1 = 32'hFFFF_FFF9; val2 = 32'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("fl_busy_pre", {31'b0, busy}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    funct3 = F3_ADD; muldiv = 1'b0; val1 = 32'd5; val2 = 32'd5; in_valid = 1'b1;
    #1;
    chk("fl_inrdy", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_busy",  {31'b0, busy},      32'd0);
    chk("fl_vld",   {31'b0, out_valid}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("fl_novld", {31'b0, seen}, 32'd0);
    op_chk("fl_add", F3_ADD, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2, 1);

    // Reset at cycle 10 of a DIV
    @(negedge clk);
    funct3 = F3_DIV; mod = 1'b0; muldiv = 1'b1; val1 = 32'hFFFF_FFF9; val2 = 32'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rs_busy",   {31'b0, busy},      32'd0);
    chk("rs_vld",    {31'b0, out_valid}, 32'd0);
    chk("rs_result", result,             32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rs_novld", {31'b0, seen}, 32'd0);
    op_chk("rs_add", F3_ADD, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
